rx_fifo_pack: RTL

// Byte-to-word packing receive FIFO; the inverse of the 128->8 transmit FIFO on the same datapath.

---
 rtl/rx_fifo_pkg.sv | 27 ++
 rtl/rx_fifo_word_ram.sv | 32 +++
 rtl/rx_fifo_pack.sv | 109 ++++++++++
 3 files changed

// File: rtl/rx_fifo_pkg.sv
// Shared widths, the stored entry layout and the byte-lane insert helper
// for the byte-to-word receive FIFO.
package rx_fifo_pkg;
    localparam int LANES  = 16;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 128;
    localparam int CNT_W  = 5;

    typedef struct packed {
        logic [CNT_W-1:0]  cnt;
        logic [WORD_W-1:0] data;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // Little-endian lane placement: lane n occupies bits [8n+7:8n].
    function automatic logic [WORD_W-1:0] insert_byte(
        input logic [WORD_W-1:0] word,
        input logic [3:0]        lane,
        input logic [BYTE_W-1:0] value
    );
        logic [WORD_W-1:0] result;
        result = word;
        result[lane*BYTE_W +: BYTE_W] = value;
        return result;
    endfunction
endpackage

// File: rtl/rx_fifo_word_ram.sv
// Simple dual-port word store: synchronous write, synchronous registered read.
// The read register clears on reset so the consumer sees zero before any read.
module rx_fifo_word_ram
    import rx_fifo_pkg::*;
#(
    parameter int DEPTH_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [DEPTH_WIDTH-1:0] waddr,
    input  logic [ENTRY_W-1:0]     wdata,
    input  logic                   re,
    input  logic [DEPTH_WIDTH-1:0] raddr,
    output logic [ENTRY_W-1:0]     rdata
);
    logic [ENTRY_W-1:0] mem [0:(1<<DEPTH_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/rx_fifo_pack.sv
// Packs one byte per clock into 128-bit little-endian words and buffers them
// for a word consumer; flush pushes a partial word tagged with its byte count.
module rx_fifo_pack
    import rx_fifo_pkg::*;
#(
    parameter int DEPTH_WIDTH      = 8,
    parameter int ALMOST_FULL_NUM  = 240,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    input  logic                   flush,
    output logic                   wr_full,
    output logic                   almost_full,
    input  logic                   rd_en,
    output logic [127:0]           rd_data,
    output logic [4:0]             rd_bytes,
    output logic                   rd_empty,
    output logic                   almost_empty,
    output logic [DEPTH_WIDTH:0]   rd_water_level
);
    localparam logic [DEPTH_WIDTH:0] FULL_LVL = (DEPTH_WIDTH+1)'(1 << DEPTH_WIDTH);
    localparam logic [DEPTH_WIDTH:0] AF_LVL   = (DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
    localparam logic [DEPTH_WIDTH:0] AE_LVL   = (DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);

    logic [3:0]             idx, idx_next;
    logic [WORD_W-1:0]      pack, pack_with_byte, pack_next;
    logic [CNT_W-1:0]       count;
    logic                   wr_ok, flush_ok, push, pop;
    entry_t                 push_entry;
    logic [ENTRY_W-1:0]     ram_rdata;
    logic [DEPTH_WIDTH-1:0] wptr, rptr;
    logic [DEPTH_WIDTH:0]   level_next;

    // count is the number of valid lanes once this cycle's byte is included;
    // it reaches 16 only when an accepted byte lands in lane 15.
    always_comb begin
        wr_ok          = wr_en & ~wr_full;
        flush_ok       = flush & ~wr_full;
        pack_with_byte = wr_ok ? insert_byte(pack, idx, wr_data) : pack;
        count          = {1'b0, idx} + {4'b0000, wr_ok};
        push           = 1'b0;
        idx_next       = count[3:0];
        pack_next      = pack_with_byte;
        if (count == 5'd16 || (flush_ok && count != 5'd0)) begin
            push      = 1'b1;
            idx_next  = 4'd0;
            pack_next = '0;
        end
        push_entry.cnt  = count;
        push_entry.data = pack_with_byte;
        pop             = rd_en & ~rd_empty;
        level_next      = rd_water_level + (DEPTH_WIDTH+1)'(push) - (DEPTH_WIDTH+1)'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx  <= 4'd0;
            pack <= '0;
        end else begin
            idx  <= idx_next;
            pack <= pack_next;
        end
    end

    // Push never targets the read slot: a push needs level < depth, so wptr != rptr
    // whenever both are active with stored data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr           <= '0;
            rptr           <= '0;
            rd_water_level <= '0;
            wr_full        <= 1'b0;
            almost_full    <= 1'b0;
            rd_empty       <= 1'b1;
            almost_empty   <= 1'b1;
        end else begin
            if (push) begin
                wptr <= wptr + DEPTH_WIDTH'(1);
            end
            if (pop) begin
                rptr <= rptr + DEPTH_WIDTH'(1);
            end
            rd_water_level <= level_next;
            wr_full        <= (level_next == FULL_LVL);
            almost_full    <= (level_next >= AF_LVL);
            rd_empty       <= (level_next == '0);
            almost_empty   <= (level_next <= AE_LVL);
        end
    end

    rx_fifo_word_ram #(
        .DEPTH_WIDTH(DEPTH_WIDTH)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (push),
        .waddr(wptr),
        .wdata(push_entry),
        .re   (pop),
        .raddr(rptr),
        .rdata(ram_rdata)
    );

    assign rd_bytes = ram_rdata[ENTRY_W-1 -: CNT_W];
    assign rd_data  = ram_rdata[WORD_W-1:0];
endmodule
